de1_soc_sysid_checker: RTL and testbench

//  Avalon-MM read initiator that interrogates the system-ID slave after boot or on request.

---
 rtl/de1_soc_sysid_checker_pkg.sv | 28 ++
 rtl/de1_soc_sysid_checker_timeout_ctr.sv | 38 +++
 rtl/de1_soc_sysid_checker.sv | 213 +++++++++++++++++++++
 tb/tb_de1_soc_sysid_checker.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/de1_soc_sysid_checker_pkg.sv
// Shared definitions for the system-ID checker: FSM state encodings,
// sysid word addresses and the default expected ID/timestamp values.
package de1_soc_sysid_checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ID_REQ  = 3'd1,
        ST_ID_WAIT = 3'd2,
        ST_TS_REQ  = 3'd3,
        ST_TS_WAIT = 3'd4,
        ST_FINISH  = 3'd5
    } sysid_state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_DEFAULT_ID = 32'h0000_0000;
    localparam logic [31:0] SYSID_DEFAULT_TS = 32'h5279_DF09;

    function automatic logic is_req_state(input sysid_state_e s);
        return (s == ST_ID_REQ) || (s == ST_TS_REQ);
    endfunction

    function automatic logic is_wait_state(input sysid_state_e s);
        return (s == ST_ID_WAIT) || (s == ST_TS_WAIT);
    endfunction

endpackage

// File: rtl/de1_soc_sysid_checker_timeout_ctr.sv
// Per-attempt read timeout: counts enabled cycles from a clear and flags the
// cycle in which TIMEOUT_CYCLES-1 is reached.
module sysid_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/de1_soc_sysid_checker.sv
// Avalon-MM read initiator that fetches sysid words 0 (ID) and 1 (timestamp)
// and flags mismatches/timeouts. Define SYSID_CHECK_AUTOSTART_EN to auto-run once after reset.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for start
// ST_ID_REQ  | avm_read high at address 0 until waitrequest drops
// ST_ID_WAIT | waiting for (or holding) the ID readdatavalid
// ST_TS_REQ  | avm_read high at address 1 until waitrequest drops
// ST_TS_WAIT | waiting for (or holding) the timestamp readdatavalid
// ST_FINISH  | one-cycle done pulse, pass resolved
module de1_soc_sysid_checker
    import de1_soc_sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter int          RETRIES        = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam int RW = (RETRIES < 1) ? 1 : $clog2(RETRIES + 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(RETRIES);

    sysid_state_e state_q, state_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          got_q, got_d;
    logic [31:0]   id_value_q, id_value_d;
    logic [31:0]   ts_value_q, ts_value_d;
    logic          id_mm_q, id_mm_d;
    logic          ts_mm_q, ts_mm_d;
    logic          timeout_q, timeout_d;
    logic          pass_q, pass_d;

    logic start_int;
    logic req_st;
    logic wait_st;
    logic word_ts;
    logic take;
    logic ctr_clear;
    logic ctr_expired;

`ifdef SYSID_CHECK_AUTOSTART_EN
    logic auto_q;
    logic auto_d;

    assign auto_d = 1'b0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            auto_q <= 1'b1;
        end else begin
            auto_q <= auto_d;
        end
    end

    assign start_int = start | auto_q;
`else
    assign start_int = start;
`endif

    assign req_st  = is_req_state(state_q);
    assign wait_st = is_wait_state(state_q);
    assign word_ts = (state_q == ST_TS_REQ) || (state_q == ST_TS_WAIT);

    // A response in the accept cycle is taken so zero-latency slaves work.
    assign take = avm_readdatavalid &&
                  ((req_st && !avm_waitrequest) || (wait_st && !got_q));

    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        got_d      = got_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;
        id_mm_d    = id_mm_q;
        ts_mm_d    = ts_mm_q;
        timeout_d  = timeout_q;
        pass_d     = pass_q;
        ctr_clear  = 1'b0;

        if (take) begin
            if (word_ts) begin
                ts_value_d = avm_readdata;
                ts_mm_d    = (avm_readdata != EXPECTED_TS);
            end else begin
                id_value_d = avm_readdata;
                id_mm_d    = (avm_readdata != EXPECTED_ID);
            end
        end

        case (state_q)
            ST_IDLE: begin
                ctr_clear = 1'b1;
                if (start_int) begin
                    state_d   = ST_ID_REQ;
                    pass_d    = 1'b0;
                    id_mm_d   = 1'b0;
                    ts_mm_d   = 1'b0;
                    timeout_d = 1'b0;
                    retry_d   = '0;
                    got_d     = 1'b0;
                end
            end
            ST_ID_REQ, ST_TS_REQ: begin
                if (!avm_waitrequest) begin
                    state_d = word_ts ? ST_TS_WAIT : ST_ID_WAIT;
                    got_d   = take;
                end
            end
            ST_ID_WAIT: begin
                if (got_q || take) begin
                    state_d   = ST_TS_REQ;
                    ctr_clear = 1'b1;
                    retry_d   = '0;
                    got_d     = 1'b0;
                end
            end
            ST_TS_WAIT: begin
                if (got_q || take) begin
                    state_d = ST_FINISH;
                    got_d   = 1'b0;
                end
            end
            ST_FINISH: begin
                ctr_clear = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Expiry overrides any REQ->WAIT move made in the same cycle.
        if ((req_st || wait_st) && !got_q && !take && ctr_expired) begin
            if (retry_q < RETRY_MAX) begin
                state_d   = word_ts ? ST_TS_REQ : ST_ID_REQ;
                retry_d   = retry_q + 1'b1;
                ctr_clear = 1'b1;
                got_d     = 1'b0;
            end else begin
                timeout_d = 1'b1;
                state_d   = ST_FINISH;
            end
        end

        if ((state_d == ST_FINISH) && (state_q != ST_FINISH)) begin
            pass_d = !id_mm_d && !ts_mm_d && !timeout_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            retry_q    <= '0;
            got_q      <= 1'b0;
            id_value_q <= '0;
            ts_value_q <= '0;
            id_mm_q    <= 1'b0;
            ts_mm_q    <= 1'b0;
            timeout_q  <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            retry_q    <= retry_d;
            got_q      <= got_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
            id_mm_q    <= id_mm_d;
            ts_mm_q    <= ts_mm_d;
            timeout_q  <= timeout_d;
            pass_q     <= pass_d;
        end
    end

    sysid_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (ctr_clear),
        .enable  (req_st || wait_st),
        .expired (ctr_expired)
    );

    assign avm_read    = req_st;
    assign avm_address = word_ts ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_FINISH);
    assign pass        = pass_q;
    assign id_mismatch = id_mm_q;
    assign ts_mismatch = ts_mm_q;
    assign timeout     = timeout_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_de1_soc_sysid_checker.sv
// Directed bench for de1_soc_sysid_checker with a configurable sysid slave model.
// Build with SYSID_CHECK_AUTOSTART_EN defined to exercise the auto-start path.
module tb_de1_soc_sysid_checker;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;
    logic [31:0] id_value, ts_value;

    int tests = 0;
    int fails = 0;

    int          cfg_stall = 0;
    int          cfg_lat = 0;
    bit          silent = 1'b0;
    bit          spur = 1'b0;
    logic [31:0] id_word = 32'h0000_0000;
    logic [31:0] ts_word = 32'h5279_DF09;
    int          stall_cnt = 0;
    int          pend = 0;
    logic        pend_addr = 1'b0;
    int          acc_id = 0;
    int          acc_ts = 0;
    int          stall_viol = 0;
    logic        prev_stalled = 1'b0;
    logic        prev_addr = 1'b0;
    int          n;

    always #5 clock = ~clock;

    de1_soc_sysid_checker #(
        .TIMEOUT_CYCLES(16),
        .RETRIES(3)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .start             (start),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .busy              (busy),
        .done              (done),
        .pass              (pass),
        .id_mismatch       (id_mismatch),
        .ts_mismatch       (ts_mismatch),
        .timeout           (timeout),
        .id_value          (id_value),
        .ts_value          (ts_value)
    );

    // Slave model: drives responses for the current cycle at the falling edge.
    initial begin
        forever begin
            @(negedge clock);
            avm_readdatavalid = 1'b0;
            avm_waitrequest   = 1'b0;
            if (!reset_n) begin
                prev_stalled = 1'b0;
                pend         = 0;
                stall_cnt    = 0;
            end else begin
                if (prev_stalled && (!avm_read || (avm_address !== prev_addr))) stall_viol++;
                prev_stalled = 1'b0;
                if (spur) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = 32'hDEAD_BEEF;
                end
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        avm_readdatavalid = 1'b1;
                        avm_readdata      = pend_addr ? ts_word : id_word;
                    end
                end
                if (avm_read && !silent) begin
                    if (stall_cnt < cfg_stall) begin
                        avm_waitrequest = 1'b1;
                        stall_cnt++;
                        prev_stalled = 1'b1;
                        prev_addr    = avm_address;
                    end else begin
                        stall_cnt = 0;
                        if (cfg_lat == 0) begin
                            avm_readdatavalid = 1'b1;
                            avm_readdata      = avm_address ? ts_word : id_word;
                        end else begin
                            pend      = cfg_lat;
                            pend_addr = avm_address;
                        end
                    end
                end
                if (avm_read && !avm_waitrequest) begin
                    if (avm_address) acc_ts++;
                    else acc_id++;
                end
            end
        end
    end

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Called one cycle into ID_REQ; returns cycles from the start cycle to done.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 200) begin
            step();
            cyc++;
        end
    endtask

    initial begin
        #12;
        check("reset ctrl", {24'd0, busy, done, pass, id_mismatch, ts_mismatch, timeout, avm_read, avm_address}, 32'd0);
        check("reset id_value", id_value, 32'd0);
        check("reset ts_value", ts_value, 32'd0);

        @(negedge clock);
        reset_n = 1'b1;
        step();
`ifdef SYSID_CHECK_AUTOSTART_EN
        check("autostart read", {31'd0, avm_read}, 32'd1);
        wait_done(n);
        check("autostart latency", n, 32'd5);
        check("autostart pass", {31'd0, pass}, 32'd1);
`else
        check("no autostart", {31'd0, avm_read}, 32'd0);
`endif

        // Zero-latency, no stalls: nominal pass in 5 cycles.
        step();
        step();
        pulse_start();
        wait_done(n);
        check("t1 latency", n, 32'd5);
        check("t1 pass", {31'd0, pass}, 32'd1);
        check("t1 flags", {29'd0, id_mismatch, ts_mismatch, timeout}, 32'd0);
        check("t1 ts_value", ts_value, 32'h5279_DF09);

        // start during FINISH ignored, start in the following cycle accepted.
        ts_word = 32'h5279_DF0A;
        start = 1'b1;
        step();
        check("start in finish ignored", {31'd0, busy}, 32'd0);
        step();
        start = 1'b0;
        check("start after done taken", {31'd0, busy}, 32'd1);
        wait_done(n);
        check("t2 latency", n, 32'd5);
        check("t2 ts_mismatch", {31'd0, ts_mismatch}, 32'd1);
        check("t2 id_mismatch", {31'd0, id_mismatch}, 32'd0);
        check("t2 pass", {31'd0, pass}, 32'd0);
        check("t2 ts_value", ts_value, 32'h5279_DF0A);

        // Stray readdatavalid while idle must not be captured.
        step();
        spur = 1'b1;
        step();
        spur = 1'b0;
        step();
        check("spurious id_value", id_value, 32'd0);
        check("spurious ts_value", ts_value, 32'h5279_DF0A);

        // 4-cycle waitrequest, readdatavalid 2 cycles after accept.
        ts_word    = 32'h5279_DF09;
        cfg_stall  = 4;
        cfg_lat    = 2;
        stall_viol = 0;
        pulse_start();
        wait_done(n);
        check("t3 latency", n, 32'd15);
        check("t3 pass", {31'd0, pass}, 32'd1);
        check("t3 stall stability", stall_viol, 32'd0);

        // Silent slave: 4 ID attempts, then timeout, no timestamp read.
        cfg_stall = 0;
        cfg_lat   = 0;
        silent    = 1'b1;
        acc_id    = 0;
        acc_ts    = 0;
        step();
        pulse_start();
        wait_done(n);
        check("t4 latency", n, 32'd65);
        check("t4 timeout", {31'd0, timeout}, 32'd1);
        check("t4 pass", {31'd0, pass}, 32'd0);
        check("t4 id attempts", acc_id, 32'd4);
        check("t4 ts attempts", acc_ts, 32'd0);

        // Asynchronous reset mid-transaction (timestamp request stalled).
        silent    = 1'b0;
        cfg_stall = 4;
        step();
        pulse_start();
        n = 0;
        while (!(avm_read && avm_address) && n < 50) begin
            step();
            n++;
        end
        check("t5 ts request reached", {30'd0, avm_read, avm_address}, 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5 async read drop", {31'd0, avm_read}, 32'd0);
        check("t5 async busy drop", {31'd0, busy}, 32'd0);
        #10;
        cfg_stall = 0;
        @(negedge clock);
        reset_n = 1'b1;
`ifdef SYSID_CHECK_AUTOSTART_EN
        step();
`else
        pulse_start();
`endif
        wait_done(n);
        check("t5 restart latency", n, 32'd5);
        check("t5 restart pass", {31'd0, pass}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
